// File: rtl/i2c_slave_if.sv
`timescale 1ns/1ps
// Application-side handshake of the I2C target: received bytes, bytes to
// transmit and selection status. The slave modport is the I2C block itself.
interface i2c_slave_if;
  logic       busy;
  logic       addressed;
  logic       rw;
  logic [7:0] data_rx;
  logic       rx_valid;
  logic       rx_nack;
  logic [7:0] data_tx;
  logic       tx_request;
  logic       tx_valid;
  logic       master_nack;

  modport slave (
    output busy, addressed, rw, data_rx, rx_valid, tx_request, master_nack,
    input  rx_nack, data_tx, tx_valid
  );

  modport master (
    input  busy, addressed, rw, data_rx, rx_valid, tx_request, master_nack,
    output rx_nack, data_tx, tx_valid
  );
endinterface

// File: rtl/i2c_slave.sv
`timescale 1ns/1ps
// Single-address I2C target: glitch-filtered SCL/SDA, START/STOP detection,
// byte receive/transmit with optional clock stretching before read bytes.
module i2c_slave #(
  parameter int unsigned INPUT_CLK_RATE   = 50_000_000,
  parameter logic [6:0]  ADDRESS          = 7'h2A,
  parameter bit          CLOCK_STRETCHING = 1'b0,
  parameter int unsigned FILTER_DEPTH     = 3
) (
  input  logic       clk_in,
  input  logic       reset,
  inout  wire        scl,
  inout  wire        sda,
  i2c_slave_if.slave app
);

  generate
    if (INPUT_CLK_RATE == 0 || FILTER_DEPTH == 0) begin : g_bad_params
      $error("i2c_slave: INPUT_CLK_RATE and FILTER_DEPTH must be non-zero");
    end
  endgenerate

  localparam int CNT_W = $clog2(FILTER_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
  } state_t;

  state_t state, state_d;

  logic [1:0]       line_sync1, line_sync2, line_filt, line_filt_q;
  logic [CNT_W-1:0] filt_cnt [2];

  logic       sda_low, sda_low_d, scl_low, scl_low_d, tx_wait, tx_wait_d;
  logic       busy, busy_d, addressed, addressed_d, rw, rw_d, nack_q, nack_d;
  logic [7:0] data_rx, data_rx_d, shift_rx, shift_rx_d, tx_shift, tx_shift_d;
  logic [3:0] bit_cnt, bit_cnt_d;
  logic       rx_valid, rx_valid_d, tx_request, tx_request_d;
  logic       master_nack, master_nack_d;
  logic       start_byte, can_load;

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, addr_match;

  // Bit 1 is SCL, bit 0 is SDA; a level flips only after FILTER_DEPTH
  // consecutive samples disagree with the accepted level.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      line_sync1  <= 2'b11;
      line_sync2  <= 2'b11;
      line_filt   <= 2'b11;
      line_filt_q <= 2'b11;
      for (int i = 0; i < 2; i++) filt_cnt[i] <= '0;
    end else begin
      line_sync1  <= {scl, sda};
      line_sync2  <= line_sync1;
      line_filt_q <= line_filt;
      for (int i = 0; i < 2; i++) begin
        if (line_sync2[i] == line_filt[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == CNT_W'(FILTER_DEPTH - 1)) begin
          line_filt[i] <= line_sync2[i];
          filt_cnt[i]  <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign scl_f      = line_filt[1];
  assign sda_f      = line_filt[0];
  assign scl_rise   = scl_f & ~line_filt_q[1];
  assign scl_fall   = ~scl_f & line_filt_q[1];
  assign start_det  = scl_f & line_filt_q[1] & line_filt_q[0] & ~sda_f;
  assign stop_det   = scl_f & line_filt_q[1] & ~line_filt_q[0] & sda_f;
  assign addr_match = (shift_rx[7:1] == ADDRESS) && (shift_rx[7:1] != 7'h00);
  assign can_load   = !CLOCK_STRETCHING || app.tx_valid;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (stop_det) begin
      state_d = IDLE;
    end else if (start_det) begin
      state_d = ADDR;
    end else begin
      case (state)
        ADDR:      if (scl_fall && bit_cnt == 4'd8) state_d = addr_match ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK:  if (scl_fall) state_d = shift_rx[0] ? READ : WRITE;
        WRITE:     if (scl_fall && bit_cnt == 4'd8) state_d = WRITE_ACK;
        WRITE_ACK: if (scl_fall) state_d = nack_q ? WAIT_STOP : WRITE;
        READ:      if (!tx_wait && scl_fall && bit_cnt == 4'd8) state_d = READ_ACK;
        READ_ACK: begin
          if (scl_rise && sda_f) state_d = WAIT_STOP;
          else if (scl_fall)     state_d = READ;
        end
        default: ;
      endcase
    end
  end

  // Next values of every driven line and datapath register. A read byte is
  // started (data_tx latched, MSB driven) either at the 9th fall or, while
  // stretching, as soon as tx_valid arrives.
  always_comb begin
    sda_low_d     = sda_low;
    tx_wait_d     = tx_wait;
    scl_low_d     = tx_wait;
    busy_d        = busy;
    addressed_d   = addressed;
    rw_d          = rw;
    data_rx_d     = data_rx;
    shift_rx_d    = shift_rx;
    tx_shift_d    = tx_shift;
    bit_cnt_d     = bit_cnt;
    nack_d        = nack_q;
    rx_valid_d    = 1'b0;
    tx_request_d  = 1'b0;
    master_nack_d = 1'b0;
    start_byte    = 1'b0;
    if (stop_det || start_det) begin
      sda_low_d   = 1'b0;
      scl_low_d   = 1'b0;
      tx_wait_d   = 1'b0;
      busy_d      = start_det;
      addressed_d = 1'b0;
      bit_cnt_d   = 4'd0;
      shift_rx_d  = 8'h00;
      nack_d      = 1'b0;
    end else begin
      case (state)
        ADDR, WRITE: begin
          if (scl_rise) begin
            shift_rx_d = {shift_rx[6:0], sda_f};
            bit_cnt_d  = bit_cnt + 4'd1;
            if (state == WRITE && bit_cnt == 4'd7) nack_d = app.rx_nack;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_d = 4'd0;
            if (state == ADDR) begin
              sda_low_d = addr_match;
            end else begin
              data_rx_d  = shift_rx;
              rx_valid_d = 1'b1;
              sda_low_d  = ~nack_q;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          sda_low_d   = 1'b0;
          rw_d        = shift_rx[0];
          addressed_d = 1'b1;
          start_byte  = shift_rx[0];
        end
        WRITE_ACK: if (scl_fall) sda_low_d = 1'b0;
        READ: if (!tx_wait) begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_low_d = 1'b0;
              bit_cnt_d = 4'd0;
            end else begin
              sda_low_d  = ~tx_shift[6];
              tx_shift_d = {tx_shift[6:0], 1'b0};
            end
          end
        end
        READ_ACK: begin
          if (scl_rise && sda_f) master_nack_d = 1'b1;
          else if (scl_fall)     start_byte    = 1'b1;
        end
        default: ;
      endcase
      if (start_byte || (state == READ && tx_wait)) begin
        if (can_load) begin
          tx_shift_d   = app.data_tx;
          tx_request_d = 1'b1;
          sda_low_d    = ~app.data_tx[7];
          tx_wait_d    = 1'b0;
        end else begin
          tx_wait_d = 1'b1;
          sda_low_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sda_low     <= 1'b0;
      scl_low     <= 1'b0;
      tx_wait     <= 1'b0;
      busy        <= 1'b0;
      addressed   <= 1'b0;
      rw          <= 1'b0;
      nack_q      <= 1'b0;
      data_rx     <= 8'h00;
      shift_rx    <= 8'h00;
      tx_shift    <= 8'h00;
      bit_cnt     <= 4'd0;
      rx_valid    <= 1'b0;
      tx_request  <= 1'b0;
      master_nack <= 1'b0;
    end else begin
      sda_low     <= sda_low_d;
      scl_low     <= scl_low_d;
      tx_wait     <= tx_wait_d;
      busy        <= busy_d;
      addressed   <= addressed_d;
      rw          <= rw_d;
      nack_q      <= nack_d;
      data_rx     <= data_rx_d;
      shift_rx    <= shift_rx_d;
      tx_shift    <= tx_shift_d;
      bit_cnt     <= bit_cnt_d;
      rx_valid    <= rx_valid_d;
      tx_request  <= tx_request_d;
      master_nack <= master_nack_d;
    end
  end

  assign scl = scl_low ? 1'b0 : 1'bz;
  assign sda = sda_low ? 1'b0 : 1'bz;

  assign app.busy        = busy;
  assign app.addressed   = addressed;
  assign app.rw          = rw;
  assign app.data_rx     = data_rx;
  assign app.rx_valid    = rx_valid;
  assign app.tx_request  = tx_request;
  assign app.master_nack = master_nack;

endmodule

// File: tb/tb_i2c_slave.sv
`timescale 1ns/1ps
// Bench for i2c_slave: a bit-banged bus master drives two targets on one bus
// (0x2A without stretching, 0x3B with stretching); results go through queues.
module tb_i2c_slave;
  localparam int Q = 20;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  logic m_scl_low = 1'b0;
  logic m_sda_low = 1'b0;
  wire  scl, sda;

  pullup (scl);
  pullup (sda);
  assign scl = m_scl_low ? 1'b0 : 1'bz;
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  always #5 clk_in = ~clk_in;

  i2c_slave_if hs0 ();
  i2c_slave_if hs1 ();

  i2c_slave #(
    .INPUT_CLK_RATE(100_000_000), .ADDRESS(7'h2A), .CLOCK_STRETCHING(1'b0), .FILTER_DEPTH(3)
  ) dut (
    .clk_in(clk_in), .reset(reset), .scl(scl), .sda(sda), .app(hs0.slave)
  );

  i2c_slave #(
    .INPUT_CLK_RATE(100_000_000), .ADDRESS(7'h3B), .CLOCK_STRETCHING(1'b1), .FILTER_DEPTH(3)
  ) dut_cs (
    .clk_in(clk_in), .reset(reset), .scl(scl), .sda(sda), .app(hs1.slave)
  );

  int check_count = 0;
  int fail_count  = 0;
  int rx_cnt0 = 0, tx_cnt0 = 0, mnack_cnt0 = 0, rx_cnt1 = 0, tx_cnt1 = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_rd[$];
  logic [7:0] tx_q0[$];
  logic [7:0] tx_q1[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard side: pops expected write bytes on rx_valid and feeds data_tx.
  always @(negedge clk_in) begin
    if (!reset) begin
      if (hs0.rx_valid) begin
        rx_cnt0++;
        if (exp_rx.size() != 0) checkOutput("rx_data", 32'(hs0.data_rx), 32'(exp_rx.pop_front()));
      end
      if (hs0.tx_request) begin
        tx_cnt0++;
        if (tx_q0.size() != 0) void'(tx_q0.pop_front());
      end
      if (hs0.master_nack) mnack_cnt0++;
      if (hs1.rx_valid) rx_cnt1++;
      if (hs1.tx_request) begin
        tx_cnt1++;
        if (tx_q1.size() != 0) void'(tx_q1.pop_front());
      end
    end
    hs0.data_tx = (tx_q0.size() != 0) ? tx_q0[0] : 8'h00;
    hs1.data_tx = (tx_q1.size() != 0) ? tx_q1[0] : 8'h00;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic scl_release();
    int w = 0;
    m_scl_low = 1'b0;
    while (scl !== 1'b1 && w < 2000) begin
      @(negedge clk_in);
      w++;
    end
    if (w >= 2000) checkOutput("scl_rise_timeout", 32'(scl), 32'd1);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wait_clk(Q);
    scl_release();    wait_clk(Q);
    m_sda_low = 1'b1; wait_clk(Q);
    m_scl_low = 1'b1; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_clk(Q);
    scl_release();    wait_clk(Q);
    m_sda_low = 1'b0; wait_clk(2 * Q);
  endtask

  task automatic xfer_bit(input logic b, output logic s);
    m_sda_low = ~b;   wait_clk(Q);
    scl_release();    wait_clk(Q);
    s = sda;          wait_clk(Q);
    m_scl_low = 1'b1; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], s);
    xfer_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) xfer_bit(1'b1, d[i]);
    xfer_bit(nack, s);
  endtask

  task automatic applyStimulus(input int test_no);
    logic       ack, s;
    logic [7:0] d;
    int         rx0, tx0, mn0, hi_seen;
    rx0 = rx_cnt0; tx0 = tx_cnt0; mn0 = mnack_cnt0;
    case (test_no)
      1: begin
        exp_rx.push_back(8'hA5); exp_rx.push_back(8'h3C);
        i2c_start();
        write_byte(8'h54, ack); checkOutput("t1_addr_ack", 32'(ack), 32'd0);
        checkOutput("t1_sel", {hs0.busy, hs0.addressed, hs0.rw}, 32'b110);
        write_byte(8'hA5, ack); checkOutput("t1_ack1", 32'(ack), 32'd0);
        write_byte(8'h3C, ack); checkOutput("t1_ack2", 32'(ack), 32'd0);
        i2c_stop();
        checkOutput("t1_rx_count", 32'(rx_cnt_delta(rx0)), 32'd2);
        checkOutput("t1_data_rx", 32'(hs0.data_rx), 32'h3C);
        checkOutput("t1_after_stop", {hs0.busy, hs0.addressed}, 32'b00);
      end
      2: begin
        i2c_start();
        write_byte(8'h56, ack); checkOutput("t2_addr_nack", 32'(ack), 32'd1);
        checkOutput("t2_busy_unsel", {hs0.busy, hs0.addressed, hs1.addressed}, 32'b100);
        write_byte(8'h11, ack); checkOutput("t2_data_nack", 32'(ack), 32'd1);
        i2c_stop();
        checkOutput("t2_rx_count", 32'(rx_cnt_delta(rx0)), 32'd0);
      end
      3: begin
        tx_q0.push_back(8'hFE); tx_q0.push_back(8'hED);
        exp_rd.push_back(8'hFE); exp_rd.push_back(8'hED);
        i2c_start();
        write_byte(8'h55, ack); checkOutput("t3_addr_ack", 32'(ack), 32'd0);
        checkOutput("t3_rw", 32'(hs0.rw), 32'd1);
        read_byte(1'b0, d); checkOutput("t3_rd0", 32'(d), 32'(exp_rd.pop_front()));
        read_byte(1'b1, d); checkOutput("t3_rd1", 32'(d), 32'(exp_rd.pop_front()));
        checkOutput("t3_sda_released", 32'(sda), 32'd1);
        checkOutput("t3_tx_req_count", 32'(tx_cnt0 - tx0), 32'd2);
        checkOutput("t3_mnack_count", 32'(mnack_cnt0 - mn0), 32'd1);
        i2c_stop();
      end
      4: begin
        exp_rx.push_back(8'h11); exp_rx.push_back(8'h22);
        i2c_start();
        write_byte(8'h54, ack); checkOutput("t4_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h11, ack); checkOutput("t4_ack1", 32'(ack), 32'd0);
        hs0.rx_nack = 1'b1;
        write_byte(8'h22, ack); checkOutput("t4_nack2", 32'(ack), 32'd1);
        hs0.rx_nack = 1'b0;
        write_byte(8'h33, ack); checkOutput("t4_ignored", 32'(ack), 32'd1);
        checkOutput("t4_still_addressed", 32'(hs0.addressed), 32'd1);
        i2c_stop();
        checkOutput("t4_rx_count", 32'(rx_cnt_delta(rx0)), 32'd2);
      end
      5: begin
        tx_q0.push_back(8'h5A); exp_rd.push_back(8'h5A);
        i2c_start();
        write_byte(8'h54, ack); checkOutput("t5_addr_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 4; i++) xfer_bit(1'b1, s);
        i2c_start();
        checkOutput("t5_rs_unsel", {hs0.busy, hs0.addressed}, 32'b10);
        write_byte(8'h55, ack); checkOutput("t5_addr2_ack", 32'(ack), 32'd0);
        checkOutput("t5_rw", 32'(hs0.rw), 32'd1);
        read_byte(1'b1, d); checkOutput("t5_rd", 32'(d), 32'(exp_rd.pop_front()));
        i2c_stop();
        checkOutput("t5_rx_count", 32'(rx_cnt_delta(rx0)), 32'd0);
      end
      default: begin
        hs1.tx_valid = 1'b0;
        tx_q1.push_back(8'h96);
        i2c_start();
        write_byte(8'h77, ack); checkOutput("t6_addr_ack", 32'(ack), 32'd0);
        checkOutput("t6_sel", {hs1.addressed, hs0.addressed}, 32'b10);
        m_sda_low = 1'b0; wait_clk(Q);
        m_scl_low = 1'b0;
        hi_seen = 0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk_in);
          if (scl === 1'b1) hi_seen++;
        end
        checkOutput("t6_stretch_scl_high", 32'(hi_seen), 32'd0);
        checkOutput("t6_no_early_tx_req", 32'(tx_cnt1), 32'd0);
        hs1.tx_valid = 1'b1;
        scl_release();
        checkOutput("t6_tx_req", 32'(tx_cnt1), 32'd1);
        wait_clk(Q); s = sda; checkOutput("t6_msb", 32'(s), 32'd1);
        wait_clk(Q); m_scl_low = 1'b1; wait_clk(Q);
        xfer_bit(1'b1, s); checkOutput("t6_bit6", 32'(s), 32'd0);
        checkOutput("t6_sda_driven", 32'(sda), 32'd0);
        reset = 1'b1; #1;
        checkOutput("t6_sda_reset_release", 32'(sda), 32'd1);
        wait_clk(4); reset = 1'b0; wait_clk(4);
        i2c_stop();
        tx_q1.delete();
        tx_q1.push_back(8'h01);
        hs1.tx_valid = 1'b0;
        i2c_start();
        write_byte(8'h77, ack); checkOutput("t6_addr2_ack", 32'(ack), 32'd0);
        m_sda_low = 1'b0; wait_clk(Q);
        m_scl_low = 1'b0; wait_clk(20);
        checkOutput("t6_stretch2", 32'(scl), 32'd0);
        reset = 1'b1; #1;
        checkOutput("t6_scl_reset_release", 32'(scl), 32'd1);
        wait_clk(4); reset = 1'b0; wait_clk(4);
        tx_q1.delete();
      end
    endcase
    wait_clk(4 * Q);
  endtask

  function automatic int rx_cnt_delta(input int start);
    return rx_cnt0 - start;
  endfunction

  initial begin
    hs0.rx_nack = 1'b0; hs0.tx_valid = 1'b0;
    hs1.rx_nack = 1'b0; hs1.tx_valid = 1'b1;
    wait_clk(5);
    checkOutput("rst_flags", {hs0.busy, hs0.addressed, hs0.rw, hs0.rx_valid, hs0.tx_request, hs0.master_nack}, 32'd0);
    checkOutput("rst_data_rx", 32'(hs0.data_rx), 32'd0);
    checkOutput("rst_lines", {scl, sda}, 32'b11);
    reset = 1'b0;
    wait_clk(10);
    for (int t = 1; t <= 6; t++) begin
      $display("[TB] scenario %0d", t);
      applyStimulus(t);
    end
    checkOutput("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
    checkOutput("cs_target_no_rx", 32'(rx_cnt1), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d of %0d checks failed so far", fail_count, check_count);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
